// File: rtl/fetch_unit_pkg.sv
// Shared constants for the Hack instruction fetch path.
// Reused by the pc, ROM and fetch stage.
package fetch_unit_pkg;

    localparam int WORD_WIDTH  = 16;
    localparam int FETCH_DEPTH = 2;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO holding {instruction, address} pairs.
// Flush is synchronous and clears pointers and occupancy.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int WIDTH = 2 * WORD_WIDTH,
    parameter int DEPTH = FETCH_DEPTH
) (
    input  logic                        clk,
    input  logic                        flush,
    input  logic                        push,
    input  logic                        pop,
    input  logic [WIDTH-1:0]            push_data,
    output logic [WIDTH-1:0]            head_data,
    output logic                        full,
    output logic                        empty,
    output logic [cnt_width(DEPTH)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic             do_pop;

    assign do_pop    = pop & ~empty;
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign head_data = mem[head];

    always_ff @(posedge clk) begin
        if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (do_pop) begin
                head <= head + 1'b1;
            end
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

    // Storage needs no reset; occupancy gates what is visible.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[tail] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Hack fetch stage: credit-based ROM reads into a tagged FIFO,
// presented to decode over valid/ready, flushed on redirect.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH,
    parameter int DEPTH = FETCH_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc_addr,
    output logic             pc_inc,
    input  logic             redirect,
    output logic [WIDTH-1:0] rom_addr,
    input  logic [WIDTH-1:0] rom_data,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_addr,
    output logic             instr_valid,
    input  logic             instr_ready
);

    localparam int CW = cnt_width(DEPTH);
    localparam int EW = 2 * WIDTH;

    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic [EW-1:0]    head;
    logic [EW-1:0]    last;
    logic             inflight_v;
    logic [WIDTH-1:0] inflight_addr;
    logic             flush;
    logic             pop;
    logic             issue;
    logic [CW:0]      credit;

    assign flush       = reset | redirect;
    assign rom_addr    = pc_addr;
    assign instr_valid = ~empty & ~flush;
    assign pop         = instr_valid & instr_ready;

    // Slots committed after this cycle: buffered + returning - leaving.
    assign credit = {1'b0, count}
                  + (CW+1)'(inflight_v)
                  - (CW+1)'(pop);
    assign issue  = ~flush & (credit < (CW+1)'(DEPTH));
    assign pc_inc = issue;

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_v    <= 1'b0;
            inflight_addr <= '0;
        end else begin
            inflight_v <= issue;
            if (issue) begin
                inflight_addr <= pc_addr;
            end
        end
    end

    // Last transferred entry, shown while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            last <= '0;
        end else if (pop) begin
            last <= head;
        end
    end

    always_comb begin
        {instr, instr_addr} = empty ? last : head;
        if (reset) begin
            {instr, instr_addr} = '0;
        end
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .flush     (flush),
        .push      (inflight_v),
        .pop       (pop),
        .push_data ({rom_data, inflight_addr}),
        .head_data (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    assert property (@(posedge clk) disable iff (flush)
        !(inflight_v && full))
        else $error("fetch_unit: ROM return pushed into full FIFO");

endmodule
